// File: rtl/countdown_pkg.sv
// Shared types and constants for the mm:ss countdown controller.
package countdown_pkg;

  // Run-control states; the encoding is visible on the STATE output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest legal value of a units digit and of a tens digit.
  localparam logic [3:0] UNIT_MAX = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Four BCD digits, most significant first: MM:SS.
  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } bcd_time_t;

  // Clamp a raw nibble from the preset switches to a legal digit.
  function automatic logic [3:0] sat_bcd(input logic [3:0] value, input logic [3:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/countdown_ctrl_bcd_down_digit.sv
// One BCD down-counting digit with parallel load and borrow out.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  // Load has priority; a decrement from zero wraps to MAX and borrows.
  // NOTE: registered state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= load_val;
    end else if (dec) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

  assign borrow = (digit == 4'd0) && dec;

endmodule

// File: rtl/countdown_ctrl.sv
// Run control for the mm:ss countdown: prescaler, preset, borrow chain, FSM.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic       C_CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] LD_M1,
  input  logic [3:0] LD_M0,
  input  logic [3:0] LD_S1,
  input  logic [3:0] LD_S0,
  input  logic       START,
  input  logic       CLR,
  output logic [3:0] D_M1,
  output logic [3:0] D_M0,
  output logic [3:0] D_S1,
  output logic [3:0] D_S0,
  output logic [1:0] STATE,
  output logic       TICK,
  output logic       DONE_P
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state, state_nx;
  logic [PW-1:0] presc;
  bcd_time_t     preset, cur, ld_sat, load_val;
  logic          load_acc, start_acc, tick_ev, at_one, digits_load;
  logic          tick_nx, done_p_nx;
  logic [3:0]    borrow;

  assign cur    = '{m1: D_M1, m0: D_M0, s1: D_S1, s0: D_S0};
  assign ld_sat = '{m1: sat_bcd(LD_M1, TENS_MAX), m0: sat_bcd(LD_M0, UNIT_MAX),
                    s1: sat_bcd(LD_S1, TENS_MAX), s0: sat_bcd(LD_S0, UNIT_MAX)};

  // CLR beats LOAD beats START; LOAD is only honoured while stopped.
  assign load_acc  = LOAD && !CLR && (state == ST_IDLE || state == ST_DONE);
  assign start_acc = START && !CLR && !load_acc;
  assign tick_ev   = (state == ST_RUN) && (presc == PRESC_LAST) && !CLR;
  assign at_one    = (cur == 16'h0001);

  // borrow[3] would mean decrementing 00:00; force zero instead of wrapping.
  assign digits_load = CLR || load_acc || (start_acc && state == ST_DONE) || borrow[3];
  assign load_val    = load_acc ? ld_sat : (borrow[3] ? '0 : preset);

  bcd_down_digit #(.MAX(UNIT_MAX)) u_s0 (
    .clk(C_CLK), .rst_n(RST), .load(digits_load), .load_val(load_val.s0),
    .dec(tick_ev), .digit(D_S0), .borrow(borrow[0]));
  bcd_down_digit #(.MAX(TENS_MAX)) u_s1 (
    .clk(C_CLK), .rst_n(RST), .load(digits_load), .load_val(load_val.s1),
    .dec(borrow[0]), .digit(D_S1), .borrow(borrow[1]));
  bcd_down_digit #(.MAX(UNIT_MAX)) u_m0 (
    .clk(C_CLK), .rst_n(RST), .load(digits_load), .load_val(load_val.m0),
    .dec(borrow[1]), .digit(D_M0), .borrow(borrow[2]));
  bcd_down_digit #(.MAX(TENS_MAX)) u_m1 (
    .clk(C_CLK), .rst_n(RST), .load(digits_load), .load_val(load_val.m1),
    .dec(borrow[2]), .digit(D_M1), .borrow(borrow[3]));

  // Preset captures the saturated switch value on an accepted LOAD.
  always_ff @(posedge C_CLK or negedge RST) begin
    if (!RST) begin
      preset <= '0;
    end else if (load_acc) begin
      preset <= ld_sat;
    end
  end

  // Prescaler advances in RUN, holds in PAUSE so resume keeps the partial second.
  always_ff @(posedge C_CLK or negedge RST) begin
    if (!RST) begin
      presc <= '0;
    end else if (CLR || load_acc) begin
      presc <= '0;
    end else begin
      case (state)
        ST_RUN:   presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        ST_PAUSE: presc <= presc;
        default:  presc <= '0;
      endcase
    end
  end

  // State register plus the registered TICK / DONE_P pulses.
  always_ff @(posedge C_CLK or negedge RST) begin
    if (!RST) begin
      state  <= ST_IDLE;
      TICK   <= 1'b0;
      DONE_P <= 1'b0;
    end else begin
      state  <= state_nx;
      TICK   <= tick_nx;
      DONE_P <= done_p_nx;
    end
  end

  // Next-state: reaching 00:00 on a tick outranks a coincident START.
  // NOTE: defaulting every output first keeps this block free of latches.
  always_comb begin
    state_nx = state;
    if (CLR || load_acc) begin
      state_nx = ST_IDLE;
    end else if (tick_ev && at_one) begin
      state_nx = ST_DONE;
    end else if (start_acc) begin
      case (state)
        ST_IDLE:  state_nx = (cur == '0)    ? ST_DONE : ST_RUN;
        ST_RUN:   state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_RUN;
        ST_DONE:  state_nx = (preset == '0) ? ST_DONE : ST_RUN;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // Output decode: DONE_P on any entry to DONE, including START re-entry.
  always_comb begin
    tick_nx   = tick_ev;
    done_p_nx = (state_nx == ST_DONE) && (state != ST_DONE || start_acc);
  end

  assign STATE = state;

endmodule
